khazad_host_ctrl: RTL and testbench

- Initiator-side controller for the KHAZAD core. It accepts encrypt/decrypt requests on a valid/ready input stream and drives the core's start/only_data/enc/data_in/key_in interface.
- It waits for the core's last_round pulse, captures data_out, and presents the result on a valid/ready output stream.
- It caches the last key so the 24-cycle key schedule is skipped when the key is unchanged.
- It sits between the PS-side register/stream glue and the cipher core.

---
 rtl/khazad_pkg.sv | 17 +
 rtl/khazad_host_ctrl.sv | 117 +++++++++++
 tb/tb_khazad_host_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/khazad_pkg.sv
// khazad_pkg - shared constants and state encoding for the KHAZAD host controller.
`timescale 1ns/1ps
`default_nettype none
package khazad_pkg;
  localparam int BLOCK_W          = 64;
  localparam int KEY_W            = 128;
  localparam int KEY_SCHED_CYCLES = 24;
  localparam int DATA_ONLY_CYCLES = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/khazad_host_ctrl.sv
// khazad_host_ctrl - request/response front end for the KHAZAD core with a one-entry key cache.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module khazad_host_ctrl
  import khazad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [KEY_W-1:0]   in_key,
  input  logic               in_enc,
  input  logic               key_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_err,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [KEY_W-1:0]   core_key_in,
  output logic               core_enc,
  output logic               core_start,
  output logic               core_only_data,
  input  logic [BLOCK_W-1:0] core_data_out,
  input  logic               core_last_round
);

  localparam logic [5:0] TMO_LIMIT = 6'(TIMEOUT_CYCLES);

  state_t             state;
  logic [KEY_W-1:0]   key_cache;
  logic               key_valid;
  logic               last_d;
  logic [5:0]         tmo_cnt;
  logic               accept;
  logic               done_det;
  logic               tmo_hit;

  assign accept   = (state == S_IDLE) && in_valid && in_ready;
  // The core's data is valid the cycle after its last_round pulse falls.
  assign done_det = last_d && !core_last_round;
  assign tmo_hit  = (tmo_cnt + 6'd1) == TMO_LIMIT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_IDLE;
      key_cache      <= '0;
      key_valid      <= 1'b0;
      last_d         <= 1'b0;
      tmo_cnt        <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err        <= 1'b0;
      core_data_in   <= '0;
      core_key_in    <= '0;
      core_enc       <= 1'b0;
      core_start     <= 1'b0;
      core_only_data <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready       <= 1'b0;
            core_data_in   <= in_data;
            core_key_in    <= in_key;
            core_enc       <= in_enc;
            core_only_data <= key_valid && (in_key == key_cache) && !key_flush;
            key_cache      <= in_key;
            out_err        <= 1'b0;
            core_start     <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Clear the edge detector so a stale pulse cannot complete the new operation.
          last_d  <= 1'b0;
          tmo_cnt <= '0;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          last_d <= core_last_round;
          if (done_det) begin
            out_data  <= core_data_out;
            key_valid <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (tmo_hit) begin
            out_err   <= 1'b1;
            key_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 6'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A flush wins over any cache validation in the same cycle.
      if (key_flush) key_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_khazad_host_ctrl.sv
// tb_khazad_host_ctrl - directed bench with a behavioural core using a toy invertible cipher.
`timescale 1ns/1ps
`default_nettype none
module tb_khazad_host_ctrl;
  import khazad_pkg::*;

  localparam logic [63:0] TOY_C = 64'hA5A5_A5A5_A5A5_A5A5;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_enc = 1'b0;
  logic         key_flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         out_err;
  logic [63:0]  core_data_in;
  logic [127:0] core_key_in;
  logic         core_enc;
  logic         core_start;
  logic         core_only_data;
  logic [63:0]  core_data_out;
  logic         core_last_round;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall    = 1'b0;

  khazad_host_ctrl #(.TIMEOUT_CYCLES(32)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .in_enc(in_enc), .key_flush(key_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .core_data_in(core_data_in), .core_key_in(core_key_in), .core_enc(core_enc),
    .core_start(core_start), .core_only_data(core_only_data),
    .core_data_out(core_data_out), .core_last_round(core_last_round)
  );

  always #5 CLK = ~CLK;

  // Toy cipher: encrypt = rotl8(d) ^ kk, decrypt is its exact inverse.
  function automatic logic [63:0] toy(input logic [63:0] d, input logic e, input logic [127:0] k);
    logic [63:0] kk;
    logic [63:0] t;
    kk = k[127:64] ^ k[63:0] ^ TOY_C;
    if (e) begin
      toy = {d[55:0], d[63:56]} ^ kk;
    end else begin
      t   = d ^ kk;
      toy = {t[7:0], t[63:8]};
    end
  endfunction

  // Core model: keeps the last scheduled key, re-reads data/enc when it finishes.
  logic [127:0] m_key;
  logic         m_busy;
  int           m_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      core_last_round <= 1'b0;
      core_data_out   <= '0;
    end else if (core_start && !stall) begin
      m_busy <= 1'b1;
      m_cnt  <= core_only_data ? DATA_ONLY_CYCLES : KEY_SCHED_CYCLES;
      if (!core_only_data) m_key <= core_key_in;
    end else if (core_last_round) begin
      core_last_round <= 1'b0;
      m_busy          <= 1'b0;
      core_data_out   <= toy(core_data_in, core_enc, m_key);
    end else if (m_busy && m_cnt == 1) begin
      core_last_round <= 1'b1;
      m_cnt           <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input string tag, input logic [63:0] d, input logic [127:0] k,
                           input logic e, input logic fl, input logic exp_only);
    check({tag, ".in_ready"}, 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1; in_data = d; in_key = k; in_enc = e; key_flush = fl;
    @(posedge CLK); #1;
    in_valid = 1'b0; key_flush = 1'b0;
    check({tag, ".only_data"}, 128'(core_only_data), 128'(exp_only));
    check({tag, ".issue"}, 128'({core_start, in_ready, out_err, core_enc}),
          128'({1'b1, 1'b0, 1'b0, e}));
    check({tag, ".core_in"}, 128'({core_key_in ^ k, core_data_in}), 128'(d));
  endtask

  task automatic do_req(input string tag, input logic [63:0] d, input logic [127:0] k,
                        input logic e, input logic fl, input logic exp_only,
                        input int exp_lat, input logic [63:0] exp_out, input int hold);
    int lat;
    start_req(tag, d, k, e, fl, exp_only);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    check({tag, ".out_data"}, 128'(out_data), 128'(exp_out));
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check({tag, ".hold"}, 128'({out_valid, in_ready, out_data}), 128'({1'b1, 1'b0, exp_out}));
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({tag, ".release"}, 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1;
    check("reset.outputs", 128'({in_ready, out_valid, out_err, core_start, core_only_data, core_enc}), 128'(0));
    check("reset.data", 128'({core_data_in, out_data}), 128'(0));
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("post_reset.in_ready", 128'(in_ready), 128'(1'b1));

    // Miss, then hits (decrypt after encrypt shares the cached schedule).
    do_req("enc_k0", 64'h0, 128'h0, 1'b1, 1'b0, 1'b0, 27, 64'hA5A5_A5A5_A5A5_A5A5, 0);
    do_req("dec_k0", 64'hA5A5_A5A5_A5A5_A5A5, 128'h0, 1'b0, 1'b0, 1'b1, 11, 64'h0, 0);
    do_req("hold_k0", 64'h0123_4567_89AB_CDEF, 128'h0, 1'b1, 1'b0, 1'b1, 11,
           64'h86E0_C22C_0E68_4AA4, 20);
    // One key bit changed, then same key with a flush on the handshake.
    do_req("enc_k1", 64'h0, 128'h1, 1'b1, 1'b0, 1'b0, 27, 64'hA5A5_A5A5_A5A5_A5A4, 0);
    do_req("flush_k1", 64'h0, 128'h1, 1'b1, 1'b1, 1'b0, 27, 64'hA5A5_A5A5_A5A5_A5A4, 0);

    // Stalled core: abort after 32 busy cycles.
    stall = 1'b1;
    start_req("tmo", 64'h0, 128'h1, 1'b1, 1'b0, 1'b1);
    lat = 0;
    while (!out_err && lat < 60) begin
      @(posedge CLK); #1;
      lat++;
      if (!out_err) check("tmo.no_valid", 128'(out_valid), 128'(1'b0));
    end
    stall = 1'b0;
    check("tmo.latency", 128'(lat), 128'(33));
    check("tmo.state", 128'({out_err, out_valid, in_ready}), 128'({1'b1, 1'b0, 1'b1}));
    do_req("after_tmo", 64'h0123_4567_89AB_CDEF, 128'h1, 1'b1, 1'b0, 1'b0, 27,
           64'h86E0_C22C_0E68_4AA5, 0);

    // Asynchronous reset in BUSY.
    start_req("areset", 64'h0, 128'h1, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("areset.ctrl", 128'({in_ready, out_valid, out_err, core_start, core_only_data, core_enc}), 128'(0));
    check("areset.data", 128'({core_key_in, core_data_in, out_data} != 0), 128'(0));
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("areset.in_ready", 128'(in_ready), 128'(1'b1));
    do_req("post_areset", 64'hA5A5_A5A5_A5A5_A5A4, 128'h1, 1'b0, 1'b0, 1'b0, 27, 64'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
